// File: rtl/robertson_pkg.sv
// Shared types and constants for the Robertson signed multiplier sequencer.
package robertson_pkg;

    localparam int WIDTH_DEF = 8;

    // {A[W:0], Q[W-1:0]}: one guard bit on A keeps A +/- M from overflowing.
    function automatic int sr_w(input int w);
        return 2 * w + 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/robertson_addsub.sv
// Combinational A +/- sext(M) with enable; SR_W-bit signed result.
module robertson_addsub
    import robertson_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SR_W  = sr_w(WIDTH)
) (
    input  logic [WIDTH:0]    a,
    input  logic [WIDTH-1:0]  m,
    input  logic              en,
    input  logic              sub,
    output logic [SR_W-1:0]   sum
);

    logic [SR_W-1:0] a_x, m_x;

    assign a_x = {{(SR_W-WIDTH-1){a[WIDTH]}}, a};
    assign m_x = {{(SR_W-WIDTH){m[WIDTH-1]}}, m};

    always_comb begin
        sum = a_x;
        if (en) sum = sub ? (a_x - m_x) : (a_x + m_x);
    end

endmodule

// File: rtl/robertson_sequencer.sv
// Robertson multiplier sequencer: drives the external arithmetic shift register
// with {A +/- M, Q} each step and captures the 2*WIDTH-bit product.
module robertson_sequencer
    import robertson_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SR_W  = sr_w(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 sr_enable,
    output logic                 sr_mode,
    output logic [SR_W-1:0]      sr_data,
    input  logic [SR_W-1:0]      sr_q
);

    localparam int CW = $clog2(WIDTH);

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [WIDTH-1:0] m_reg;

    logic [WIDTH:0]   as_a;
    logic [WIDTH-1:0] as_m;
    logic             as_en, as_sub;
    logic [SR_W-1:0]  as_sum;
    logic [WIDTH-1:0] q_low;
    logic             accept;

    assign accept  = (state == IDLE) && start;
    assign busy    = (state != IDLE);
    assign sr_mode = 1'b0;

    // Step 0 reuses the adder with A = 0 so the first partial product is sext(M) or 0.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        as_a      = '0;
        as_m      = m_reg;
        as_en     = 1'b0;
        as_sub    = 1'b0;
        q_low     = '0;
        sr_enable = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    as_m      = multiplicand;
                    as_en     = multiplier[0];
                    q_low     = multiplier;
                    sr_enable = 1'b1;
                    cnt_nx    = CW'(1);
                    state_nx  = RUN;
                end
            end
            RUN: begin
                as_a      = sr_q[SR_W-1:WIDTH];
                as_en     = sr_q[0];
                as_sub    = (cnt == CW'(WIDTH-1));
                q_low     = sr_q[WIDTH-1:0];
                sr_enable = 1'b1;
                cnt_nx    = cnt + CW'(1);
                if (cnt == CW'(WIDTH-1)) state_nx = DONE;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (!rst_n) sr_enable = 1'b0;
    end

    robertson_addsub #(.WIDTH(WIDTH), .SR_W(SR_W)) u_addsub (
        .a   (as_a),
        .m   (as_m),
        .en  (as_en),
        .sub (as_sub),
        .sum (as_sum)
    );

    // The shift by WIDTH drops the sign-extension bits above A'.
    assign sr_data = sr_enable ? ((as_sum << WIDTH) | SR_W'(q_low)) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            m_reg   <= '0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            done  <= (state == DONE);
            if (accept)        m_reg   <= multiplicand;
            if (state == DONE) product <= sr_q[2*WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_robertson_sequencer.sv
// Directed + random bench for robertson_sequencer with an arithmetic shift register model.
module tb_robertson_sequencer;

    localparam int W   = 8;
    localparam int SRW = 2 * W + 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic signed [W-1:0]  mc, mp;
    logic                 busy, done, sr_enable, sr_mode;
    logic [2*W-1:0]       product;
    logic [SRW-1:0]       sr_data;
    logic [SRW-1:0]       sr_q = '0;

    robertson_sequencer #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (mc),
        .multiplier   (mp),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .sr_enable    (sr_enable),
        .sr_mode      (sr_mode),
        .sr_data      (sr_data),
        .sr_q         (sr_q)
    );

    always #5 clk = ~clk;

    // Downstream register: load and arithmetic shift right by one.
    always @(posedge clk) if (sr_enable) sr_q <= {sr_data[SRW-1], sr_data[SRW-1:1]};

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ph    = 0;
    int last_done = 0;
    logic [2*W-1:0] q_exp[$];
    int             q_cyc[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic acc;
        int   pph;
        logic signed [2*W-1:0] p;
        acc = rst_n && (ph == 0) && start;
        pph = ph;
        if (acc) begin
            p = mc * mp;
            q_exp.push_back(p);
            q_cyc.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n) begin
            ph = 0; pph = 0;
            q_exp.delete(); q_cyc.delete();
        end else if (acc) ph = 1;
        else if (ph == W) ph = 0;
        else if (ph != 0) ph++;
        chk("done", done, 64'(pph == W));
        chk("busy", busy, 64'(ph != 0));
        chk("sr_mode", sr_mode, 0);
        if (ph == W) chk("sr_en_done", sr_enable, 0);
        if (ph == 0 && !start) chk("sr_en_idle", sr_enable, 0);
        if (done) begin
            last_done = cyc;
            if (q_exp.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                chk("product", product, q_exp.pop_front());
                chk("latency", cyc - q_cyc.pop_front(), W);
            end
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 4 * W) begin tick(); n++; end
        chk("done_timeout", done, 1);
    endtask

    task automatic run_op(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        logic [W:0] a9;
        mc = a; mp = b; start = 1'b1;
        #1;
        a9 = b[0] ? {a[W-1], a} : '0;
        chk("step0_sr_data", sr_data, {a9, b});
        chk("step0_sr_en", sr_enable, 1);
        tick();
        start = 1'b0;
        mc = W'($urandom); mp = W'($urandom);
        wait_done();
    endtask

    initial begin
        int d1;
        rst_n = 1'b0; start = 1'b0; mc = '0; mp = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_product", product, 0);
        chk("rst_sr_en", sr_enable, 0);
        start = 1'b1;
        #1;
        chk("rst_sr_en_start", sr_enable, 0);
        start = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // 3 x 5 with an explicit look at the first shifted value
        mc = 8'sd3; mp = 8'sd5; start = 1'b1;
        #1;
        chk("3x5_step0", sr_data, 17'h00305);
        tick();
        start = 1'b0;
        chk("3x5_shifted", sr_q, 17'h00182);
        wait_done();
        chk("3x5_prod", product, 16'h000F);

        run_op(-8'sd3, 8'sd5);     chk("m3x5", product, 16'hFFF1);
        run_op(8'sd5, -8'sd3);     chk("5xm3", product, 16'hFFF1);
        run_op(-8'sd128, -8'sd128); chk("min_x_min", product, 16'h4000);
        run_op(8'sd127, -8'sd128); chk("max_x_min", product, 16'hC080);
        run_op(8'sd0, -8'sd1);     chk("0xm1", product, 16'h0000);

        // start held through the run with operands churning, then back-to-back in the done cycle
        mc = 8'sd11; mp = -8'sd7; start = 1'b1;
        for (int i = 0; i <= W; i++) begin
            tick();
            mc = W'($urandom); mp = W'($urandom);
        end
        chk("held_done", done, 1);
        chk("held_prod", product, 16'hFFB3);
        d1 = last_done;
        mc = -8'sd9; mp = 8'sd13; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        chk("b2b_gap", last_done - d1, W + 1);
        chk("b2b_prod", product, 16'hFF8B);
        repeat (3) tick();

        // reset during step 4
        mc = 8'sd5; mp = 8'sd6; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_product", product, 0);
        chk("abort_done", done, 0);
        chk("abort_sr_en", sr_enable, 0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (W + 2) tick();
        run_op(8'sd7, 8'sd9);
        chk("7x9", product, 16'h003F);

        for (int i = 0; i < 1000; i++) begin
            run_op(W'($urandom), W'($urandom));
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (W + 2) tick();
        chk("scoreboard_empty", q_exp.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
